// File: rtl/sseg_scan_driver_if.sv
// rtl/sseg_scan_driver_if.sv - request/status bundle between the reaction-test control logic and the display driver
//
// Purpose: groups the number-load handshake and the display-mode controls
//          that the reaction-test control logic uses to drive sseg_scan_driver.
// Signals:
//   value   [15:0] binary number to display, unsigned (master -> slave)
//   load           one-cycle conversion request (master -> slave)
//   msg_sel [1:0]  display mode: 0=number, 1=blank, 2="Err", 3=blank (master -> slave)
//   dp_en          decimal point on digit 3 in number mode (master -> slave)
//   busy           conversion in progress (slave -> master)
interface sseg_scan_driver_if;
  logic [15:0] value;
  logic        load;
  logic [1:0]  msg_sel;
  logic        dp_en;
  logic        busy;

  modport master (
    output value,
    output load,
    output msg_sel,
    output dp_en,
    input  busy
  );

  modport slave (
    input  value,
    input  load,
    input  msg_sel,
    input  dp_en,
    output busy
  );
endinterface

// File: rtl/sseg_scan_driver.sv
// rtl/sseg_scan_driver.sv - double-dabble BCD converter and 4-digit multiplexed seven-segment driver
//
// Purpose: converts a binary reaction time to four BCD digits with a
//          sequential shift-and-add-3 engine (or shows a fixed message) and
//          time-multiplexes the lower four digits of a common-anode display
//          with leading-zero blanking.
// Ports:
//   CLK100MHZ   in   1  system clock
//   CPU_RESETN  in   1  synchronous active-low reset
//   bus         slave   value/load/msg_sel/dp_en in, busy out
//   AN          out  8  digit enables, active-low; AN[7:4] held at 1
//   SSEG        out  8  segments, active-low, {dp,g,f,e,d,c,b,a}
module sseg_scan_driver #(
  parameter int DIGIT_TICKS = 100_000
) (
  input  logic                 CLK100MHZ,
  input  logic                 CPU_RESETN,
  sseg_scan_driver_if.slave    bus,
  output logic [7:0]           AN,
  output logic [7:0]           SSEG
);

  localparam int                TW       = (DIGIT_TICKS > 2) ? $clog2(DIGIT_TICKS) : 1;
  localparam logic [TW-1:0]     TICK_MAX = TW'(DIGIT_TICKS - 1);
  localparam logic [15:0]       SAT_MAX  = 16'd9999;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_R     = 8'hAF;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // ---------------------------------------------------------------
  // Converter state
  // ---------------------------------------------------------------
  state_t      r_state;
  logic [15:0] r_bin;
  logic [15:0] r_bcd;
  logic [3:0]  r_cnt;
  logic [15:0] r_disp;

  state_t      w_state_nx;
  logic [15:0] w_bin_nx;
  logic [15:0] w_bcd_nx;
  logic [3:0]  w_cnt_nx;
  logic [15:0] w_disp_nx;
  logic [15:0] w_sat;
  logic [15:0] w_adj;

  // ---------------------------------------------------------------
  // Scan state
  // ---------------------------------------------------------------
  logic [TW-1:0] r_tick;
  logic [1:0]    r_digit;
  logic [7:0]    r_an;
  logic [7:0]    r_sseg;

  logic [7:0]    w_an_nx;
  logic [7:0]    w_sseg_nx;
  logic [3:0]    w_nib;
  logic          w_blank3;
  logic          w_blank2;
  logic          w_blank1;
  logic          w_blank;

  function automatic logic [7:0] f_seg(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] f_add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  assign w_sat = (bus.value > SAT_MAX) ? SAT_MAX : bus.value;

  // Add-3 correction applied to every BCD nibble before the shift.
  assign w_adj = {f_add3(r_bcd[15:12]), f_add3(r_bcd[11:8]),
                  f_add3(r_bcd[7:4]),   f_add3(r_bcd[3:0])};

  assign bus.busy = (r_state == ST_SHIFT);

  // ---------------------------------------------------------------
  // Converter FSM: next-state / datapath
  // ---------------------------------------------------------------
  always_comb begin
    w_state_nx = r_state;
    w_bin_nx   = r_bin;
    w_bcd_nx   = r_bcd;
    w_cnt_nx   = r_cnt;
    w_disp_nx  = r_disp;
    case (r_state)
      ST_IDLE: begin
        if (bus.load) begin
          w_bin_nx   = w_sat;
          w_bcd_nx   = 16'd0;
          w_cnt_nx   = 4'd0;
          w_state_nx = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // {bcd, bin} shifts left as one 32-bit register.
        w_bcd_nx = {w_adj[14:0], r_bin[15]};
        w_bin_nx = {r_bin[14:0], 1'b0};
        w_cnt_nx = r_cnt + 4'd1;
        if (r_cnt == 4'd15) begin
          // Sixteenth shift: the result is complete this edge.
          w_disp_nx  = w_bcd_nx;
          w_state_nx = ST_IDLE;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      r_state <= ST_IDLE;
      r_bin   <= 16'd0;
      r_bcd   <= 16'd0;
      r_cnt   <= 4'd0;
      r_disp  <= 16'd0;
    end else begin
      r_state <= w_state_nx;
      r_bin   <= w_bin_nx;
      r_bcd   <= w_bcd_nx;
      r_cnt   <= w_cnt_nx;
      r_disp  <= w_disp_nx;
    end
  end

  // ---------------------------------------------------------------
  // Digit scan timing
  // ---------------------------------------------------------------
  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      r_tick  <= '0;
      r_digit <= 2'd0;
    end else if (r_tick == TICK_MAX) begin
      r_tick  <= '0;
      r_digit <= r_digit + 2'd1;
    end else begin
      r_tick  <= r_tick + TW'(1);
    end
  end

  // ---------------------------------------------------------------
  // Digit content and enables
  // ---------------------------------------------------------------
  assign w_blank3 = (r_disp[15:12] == 4'd0);
  assign w_blank2 = w_blank3 && (r_disp[11:8] == 4'd0);
  assign w_blank1 = w_blank2 && (r_disp[7:4] == 4'd0);

  always_comb begin
    w_an_nx = 8'hFF;
    w_nib   = r_disp[3:0];
    w_blank = 1'b0;
    case (r_digit)
      2'd0: begin
        w_an_nx[0] = 1'b0;
        w_nib      = r_disp[3:0];
        w_blank    = 1'b0;
      end
      2'd1: begin
        w_an_nx[1] = 1'b0;
        w_nib      = r_disp[7:4];
        w_blank    = w_blank1;
      end
      2'd2: begin
        w_an_nx[2] = 1'b0;
        w_nib      = r_disp[11:8];
        w_blank    = w_blank2;
      end
      default: begin
        w_an_nx[3] = 1'b0;
        w_nib      = r_disp[15:12];
        w_blank    = w_blank3;
      end
    endcase
  end

  always_comb begin
    w_sseg_nx = SEG_BLANK;
    case (bus.msg_sel)
      2'd0: begin
        w_sseg_nx = w_blank ? SEG_BLANK : f_seg(w_nib);
        // The dp on digit 3 follows dp_en even when that digit is blanked.
        if (r_digit == 2'd3) begin
          w_sseg_nx[7] = ~bus.dp_en;
        end
      end
      2'd2: begin
        case (r_digit)
          2'd3:    w_sseg_nx = SEG_BLANK;
          2'd2:    w_sseg_nx = SEG_E;
          default: w_sseg_nx = SEG_R;
        endcase
      end
      default: begin
        w_sseg_nx = SEG_BLANK;
      end
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      r_an   <= 8'hFF;
      r_sseg <= SEG_BLANK;
    end else begin
      r_an   <= w_an_nx;
      r_sseg <= w_sseg_nx;
    end
  end

  assign AN   = r_an;
  assign SSEG = r_sseg;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// tb/tb_sseg_scan_driver.sv - scoreboard bench for sseg_scan_driver
module tb_sseg_scan_driver;

  localparam int DT = 4;

  typedef struct {
    logic [7:0] an;
    logic [7:0] sseg;
    logic       busy;
  } exp_t;

  localparam logic [7:0] SEG_TAB [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                          8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  localparam int         POW_TAB [4]  = '{1, 10, 100, 1000};

  logic       clk;
  logic       rstn;
  logic [7:0] an;
  logic [7:0] sseg;

  sseg_scan_driver_if bus ();

  sseg_scan_driver #(.DIGIT_TICKS(DT)) dut (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rstn),
    .bus        (bus),
    .AN         (an),
    .SSEG       (sseg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  // Expected segment pattern for one digit, from decimal arithmetic on the shown number.
  function automatic logic [7:0] exp_seg(input int dig, input int d,
                                         input logic [1:0] ms, input logic dp);
    logic [7:0] s;
    int         p;
    p = POW_TAB[dig];
    s = 8'hFF;
    if (ms == 2'd0) begin
      if (dig != 0 && d < p) s = 8'hFF;
      else                   s = SEG_TAB[(d / p) % 10];
      if (dig == 3 && dp) s[7] = 1'b0;
    end else if (ms == 2'd2) begin
      if (dig == 3)      s = 8'hFF;
      else if (dig == 2) s = 8'h86;
      else               s = 8'hAF;
    end
    return s;
  endfunction

  // Reference model: number shown, pending conversion, and scan position
  // counted as edges since reset release.
  int scan_n    = 0;
  int busy_left = 0;
  int mdl_disp  = 0;
  int mdl_pend  = 0;

  always @(posedge clk) begin
    exp_t       e;
    int         dig;
    logic [7:0] a;
    if (!rstn) begin
      e.an      = 8'hFF;
      e.sseg    = 8'hFF;
      e.busy    = 1'b0;
      scan_n    = 0;
      busy_left = 0;
      mdl_disp  = 0;
    end else begin
      dig    = (scan_n / DT) % 4;
      a      = 8'hFF;
      a[dig] = 1'b0;
      e.an   = a;
      e.sseg = exp_seg(dig, mdl_disp, bus.msg_sel, bus.dp_en);
      scan_n++;
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) mdl_disp = mdl_pend;
      end else if (bus.load) begin
        mdl_pend  = (int'(bus.value) > 9999) ? 9999 : int'(bus.value);
        busy_left = 16;
      end
      e.busy = (busy_left > 0);
    end
    exp_q.push_back(e);
  end

  // Monitor: the DUT presents AN/SSEG/busy every cycle; compare against the queue.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (an === e.an && sseg === e.sseg && bus.busy === e.busy)
        n_pass++;
      else
        $display("FAIL display cyc=%0d: got AN=%h SSEG=%h busy=%b, required AN=%h SSEG=%h busy=%b",
                 cyc, an, sseg, bus.busy, e.an, e.sseg, e.busy);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_load(input logic [15:0] v);
    @(negedge clk);
    bus.value = v;
    bus.load  = 1'b1;
    @(negedge clk);
    bus.load  = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output int used);
    used = 0;
    while (bus.busy === 1'b1 && used < limit) begin
      @(negedge clk);
      used++;
    end
    n_checks++;
    if (bus.busy === 1'b0)
      n_pass++;
    else
      $display("FAIL wait expired: busy still %b after %0d cycles", bus.busy, used);
  endtask

  initial begin
    int waited;
    rstn        = 1'b0;
    bus.value   = 16'd0;
    bus.load    = 1'b0;
    bus.msg_sel = 2'd0;
    bus.dp_en   = 1'b0;
    tick(5);
    n_checks++;
    if (an === 8'hFF && sseg === 8'hFF && bus.busy === 1'b0)
      n_pass++;
    else
      $display("FAIL reset state: got AN=%h SSEG=%h busy=%b, required AN=ff SSEG=ff busy=0",
               an, sseg, bus.busy);
    rstn = 1'b1;
    tick(20);

    pulse_load(16'd1234);
    wait_idle(20, waited);
    tick(40 - waited);

    pulse_load(16'd42);
    tick(40);
    pulse_load(16'hFFFF);
    tick(40);

    // second load mid-conversion must be ignored
    pulse_load(16'd1234);
    tick(4);
    pulse_load(16'd7);
    tick(40);

    pulse_load(16'd42);
    tick(40);
    bus.msg_sel = 2'd2;
    tick(20);
    bus.msg_sel = 2'd1;
    tick(20);
    bus.msg_sel = 2'd0;
    bus.dp_en   = 1'b1;
    tick(20);
    bus.dp_en   = 1'b0;

    // reset in the middle of a conversion
    pulse_load(16'd5678);
    tick(7);
    rstn = 1'b0;
    tick(1);
    rstn = 1'b1;
    tick(20);
    pulse_load(16'd5678);
    tick(40);

    // back-to-back load exactly when busy falls
    pulse_load(16'd9);
    tick(15);
    pulse_load(16'd800);
    tick(40);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      int sel;
      logic [15:0] v;
      sel = $urandom_range(0, 3);
      case (sel)
        0:       v = 16'($urandom_range(0, 9));
        1:       v = 16'($urandom_range(10, 999));
        2:       v = 16'($urandom_range(1000, 12000));
        default: v = 16'($urandom_range(0, 65535));
      endcase
      pulse_load(v);
      if ($urandom_range(0, 3) == 0) begin
        tick($urandom_range(0, 20));
        pulse_load(16'($urandom_range(0, 65535)));
      end
      bus.msg_sel = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      bus.dp_en   = 1'($urandom_range(0, 1));
      tick($urandom_range(18, 40));
    end

    tick(2);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sseg_scan_driver.md
# sseg_scan_driver

Drives the board's eight-digit, common-anode seven-segment display for the reaction-test design. It sits directly downstream of the reaction-test control logic and feeds `AN`/`SSEG` at the top level. It accepts a binary reaction time and converts it to BCD with a sequential double-dabble engine, or shows a fixed message. It then time-multiplexes the lower four digits with leading-zero blanking.

## Interface
- `DIGIT_TICKS`, default 100_000: clock cycles each digit stays lit (1 ms at 100 MHz); legal range ≥ 2.

Ports:
- `CLK100MHZ`  in  1  system clock; the only clock in the block.
- `CPU_RESETN`  in  1  reset; synchronous, active-low.
- `value`  in  16  binary number to display, unsigned.
- `load`  in  1  one-cycle request to convert `value`; honoured only when `busy`=0.
- `msg_sel`  in  2  display mode: 0=number, 1=blank, 2="Err", 3=blank.
- `dp_en`  in  1  in number mode, lights the decimal point on digit 3.
- `busy`  out  1  conversion in progress.
- `AN`  out  8  digit enables, active-low; `AN[7:4]` always 1.
- `SSEG`  out  8  segments, active-low, `{dp,g,f,e,d,c,b,a}`.

## Operation
- **Saturation:** when `load` is accepted, `value` > 9999 is replaced with 9999 before conversion.
- **Converter FSM** has two states:
  - `IDLE`: `busy`=0. An accepted `load` latches the saturated value, clears the 16-bit BCD accumulator, clears the shift count, and moves to `SHIFT`.
  - `SHIFT`: `busy`=1. Each cycle, every BCD nibble ≥ 5 gets +3, then the combined {bcd, bin} register shifts left by 1.
  - After the 16th shift, the result is copied to the display register `disp[15:0]` (4 BCD digits) and the FSM returns to `IDLE`.
- **Load while busy:** `load` is ignored. It is not queued, and the in-flight conversion is unaffected.
- **Scan:**
  - A free-running tick counter counts 0..DIGIT_TICKS-1.
  - On wrap, the digit index advances 0→1→2→3→0.
  - Digit k enables `AN[k]`=0; all other `AN` bits are 1.
- **Number mode (`msg_sel`=0):**
  - Digit k shows BCD nibble k (digit 0 = ones).
  - Leading-zero blanking: digit 3 is blank if nibble 3=0; digit 2 is blank if nibbles 3..2=0; digit 1 is blank if nibbles 3..1=0. Digit 0 is never blanked.
  - The dp on digit 3 is lit (SSEG[7]=0) iff `dp_en`=1, even if digit 3 is otherwise blank.
- **"Err" mode (`msg_sel`=2):** digit 3 is blank, digit 2 shows E (0x86), digits 1 and 0 show r (0xAF). dp is off.
- **Blank modes (`msg_sel`=1 or 3):** SSEG=0xFF on all digits; the scan continues unchanged.
- **Segment codes for 0..9:** C0, F9, A4, B0, 99, 92, 82, F8, 80, 90. Blank is FF.
- **Mode vs. conversion:** `msg_sel` and `dp_en` affect only the display and never disturb a conversion. `disp` keeps its value through message modes.

## Timing
- **Reset** (sampled on a `CLK100MHZ` edge with `CPU_RESETN`=0):
  - Outputs: `busy`=0, `AN`=8'hFF, `SSEG`=8'hFF.
  - Internal state: `disp`=0, tick counter=0, digit index=0, FSM=`IDLE`.
  - Reset mid-conversion aborts it, and `disp` returns to 0.
- **First scan after reset:** on the first cycle after reset release, `AN`/`SSEG` show digit 0 (number mode: 0xC0 with AN=8'hFE).
- **Output registration:** `AN` and `SSEG` are registered, so they reflect the digit index, `disp`, `msg_sel` and `dp_en` with exactly 1 cycle of latency.
- **Conversion latency:**
  - `load` is sampled at edge N, and `busy`=1 from after edge N.
  - The 16 shifts occur at edges N+1..N+16.
  - `disp` updates at edge N+16, and `busy`=0 after edge N+16, so `busy` is high for exactly 16 cycles.
  - The new value reaches `SSEG` at edge N+17 for whichever digit is being scanned.
- **Back-to-back loads:** a `load` in the cycle `busy` falls is accepted, giving a minimum load spacing of 17 cycles.
- **Digit dwell:** each digit dwells exactly DIGIT_TICKS cycles; a full refresh takes 4·DIGIT_TICKS cycles.

## Test plan
Run all scenarios with DIGIT_TICKS=4.
- Reset held 5 cycles, then released → `AN`=FF and `SSEG`=FF during reset. Then AN cycles FE, FD, FB, F7 at 4 cycles each, with SSEG = C0, FF, FF, FF.
- `value`=1234, `load` pulse → `busy` high for exactly 16 cycles. Then the scan shows digit 0=99, digit 1=B0, digit 2=A4, digit 3=F9.
- `value`=42, then `value`=0xFFFF → the first shows digits 3..0 = FF, FF, 99, A4. The second saturates to 9999, giving 90 on all four digits.
- `load` pulsed again 5 cycles into a conversion of 1234 with `value`=7 → the second load is ignored, `busy` is high for 16 cycles total, and the display shows 1234.
- `msg_sel`=2, then 1, then 0 with `dp_en`=1 after `disp`=0042 → first FF/86/AF/AF on digits 3..0. Then all FF. Then digit 3=7F and digits 2..0 = FF, 99, A4.
- `CPU_RESETN` low for 1 cycle at shift 8 of a conversion of 5678 → `busy`=0 and `disp`=0, so the display shows "0" only. A following `load` of 5678 converts correctly.
